// File: rtl/store_pkg.sv
// Shared store definitions: memow_ctrl size codes, store FSM states and the
// alignment rule used when STORE_MERGE_ALIGN_CHECK_EN is defined.
package store_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } store_state_e;

    // Bytes are always aligned; halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] offset);
        logic bad;
        case (sz)
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Little-endian sub-word lane merge: replaces one byte or half of the read
// word with store data, preserving every other bit.
module lane_merge
    import store_pkg::*;
(
    input  logic [31:0] i_rbuf,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_merged
);

    // Select the destination lane from the size code and the low address bits.
    always_comb begin
        o_merged = i_rbuf;
        case (i_size)
            SZ_BYTE: begin
                case (i_offset)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    2'd3:    o_merged[31:24] = i_wdata[7:0];
                    default: o_merged        = i_rbuf;
                endcase
            end
            SZ_HALF: begin
                if (i_offset[1]) begin
                    o_merged[31:16] = i_wdata;
                end else begin
                    o_merged[15:0] = i_wdata;
                end
            end
            default: o_merged = i_rbuf;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store back end: direct word writes, read-modify-write for byte/half stores,
// busy/done handshake. Optional alignment trap: STORE_MERGE_ALIGN_CHECK_EN.
module store_merge_unit
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              align_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] LAT_W = 3'(MEM_LAT);

    store_state_e      r_state;
    store_state_e      w_next_state;
    logic [2:0]        r_cnt;
    logic [1:0]        r_size;
    logic [1:0]        r_offset;
    logic [15:0]       r_wdata_lo;
    logic [31:0]       r_rbuf;
    logic [31:0]       w_merged;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              w_accept;
    logic              w_read_last;
    logic              w_misaligned;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_read_last = (r_state == ST_READ) && (r_cnt == LAT_W);

`ifdef STORE_MERGE_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(size, addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    lane_merge u_lane_merge (
        .i_rbuf   (r_rbuf),
        .i_wdata  (r_wdata_lo),
        .i_size   (r_size),
        .i_offset (r_offset),
        .o_merged (w_merged)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_misaligned) begin
                        w_next_state = ST_DONE;
                    end else begin
                        case (size)
                            SZ_WORD: w_next_state = ST_WRITE;
                            SZ_BYTE: w_next_state = ST_READ;
                            SZ_HALF: w_next_state = ST_READ;
                            default: w_next_state = ST_DONE;
                        endcase
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                if (r_cnt == LAT_W) begin
                    w_next_state = ST_MERGE;
                end else begin
                    w_next_state = ST_READ;
                end
            end
            ST_MERGE: w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture, read-latency counter and read/merge buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 3'd0;
            r_size     <= 2'd0;
            r_offset   <= 2'd0;
            r_wdata_lo <= 16'd0;
            r_rbuf     <= 32'd0;
        end else begin
            if (w_accept) begin
                r_size     <= size;
                r_offset   <= addr[1:0];
                r_wdata_lo <= wdata[15:0];
            end
            if ((r_state == ST_READ) && !w_read_last) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= 3'd0;
            end
            if (w_read_last) begin
                r_rbuf <= mem_rdata;
            end else if (r_state == ST_MERGE) begin
                r_rbuf <= w_merged;
            end
        end
    end

    // Moore outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= 32'd0;
        end else begin
            r_busy   <= (w_next_state != ST_IDLE);
            r_done   <= (w_next_state == ST_DONE);
            r_mem_wr <= (w_next_state == ST_WRITE);
            if (w_accept) begin
                r_mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            end
            if (w_accept && (w_next_state == ST_WRITE)) begin
                r_mem_wdata <= wdata;
            end else if (r_state == ST_MERGE) begin
                r_mem_wdata <= w_merged;
            end
        end
    end

`ifdef STORE_MERGE_ALIGN_CHECK_EN
    logic r_align_err;

    // Sticky trap flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_align_err <= 1'b0;
        end else if (w_accept && w_misaligned) begin
            r_align_err <= 1'b1;
        end else begin
            r_align_err <= r_align_err;
        end
    end

    assign align_err = r_align_err;
`else
    assign align_err = 1'b0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each backed by a small RAM model with matching read latency.
`timescale 1ns/1ps
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        start1, busy1, done1, aerr1, wr1;
    logic [31:0] maddr1, mwd1, mrd1;
    logic        start3, busy3, done3, aerr3, wr3;
    logic [31:0] maddr3, mwd3, mrd3;

    logic [31:0] ram1 [0:63];
    logic [31:0] ram3 [0:63];
    logic        ld1, ld3;
    logic [5:0]  ld_idx;
    logic [31:0] ld_val;
    logic [31:0] p1, p3a, p3b, p3c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_merge_unit #(.MEM_LAT(1), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .align_err(aerr1), .mem_addr(maddr1),
        .mem_wr(wr1), .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    store_merge_unit #(.MEM_LAT(3), .ADDR_W(32)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy3), .done(done3), .align_err(aerr3), .mem_addr(maddr3),
        .mem_wr(wr3), .mem_wdata(mwd3), .mem_rdata(mrd3)
    );

    always @(posedge clk) begin
        if (ld1) ram1[ld_idx] <= ld_val;
        else if (wr1) ram1[maddr1[7:2]] <= mwd1;
        p1 <= ram1[maddr1[7:2]];
    end
    assign mrd1 = p1;

    always @(posedge clk) begin
        if (ld3) ram3[ld_idx] <= ld_val;
        else if (wr3) ram3[maddr3[7:2]] <= mwd3;
        p3a <= ram3[maddr3[7:2]];
        p3b <= p3a;
        p3c <= p3b;
    end
    assign mrd3 = p3c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int which, input logic [5:0] idx, input logic [31:0] val);
        ld_idx = idx;
        ld_val = val;
        if (which == 1) ld1 = 1'b1; else ld3 = 1'b1;
        tick();
        ld1 = 1'b0;
        ld3 = 1'b0;
    endtask

    // Issue one store and observe it until done (bounded to 20 cycles).
    task automatic do_store(input int which, input logic [1:0] sz, input logic [31:0] ad,
                            input logic [31:0] wd, output int wr_cyc, output int wr_cnt,
                            output int done_cyc, output logic [31:0] wa, output logic [31:0] wv);
        logic w, d;
        logic [31:0] a, v;
        wr_cyc = -1; wr_cnt = 0; done_cyc = -1; wa = 32'd0; wv = 32'd0;
        size = sz; addr = ad; wdata = wd;
        if (which == 1) start1 = 1'b1; else start3 = 1'b1;
        tick();
        start1 = 1'b0; start3 = 1'b0;
        size = ~sz; addr = ~ad; wdata = ~wd;
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            if (which == 1) begin w = wr1; d = done1; a = maddr1; v = mwd1; end
            else begin w = wr3; d = done3; a = maddr3; v = mwd3; end
            if (w) begin
                wr_cnt++;
                if (wr_cyc < 0) begin wr_cyc = c; wa = a; wv = v; end
            end
            if (d) done_cyc = c;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start1 = 1'b0; start3 = 1'b0; ld1 = 1'b0; ld3 = 1'b0;
        size = 2'd0; addr = 32'd0; wdata = 32'd0; ld_idx = 6'd0; ld_val = 32'd0;
        tick(); tick();
        total++; if ({busy1, done1, wr1, aerr1} !== 4'b0000) begin bad++; $display("FAIL reset_ctl1: got %b want 0000", {busy1, done1, wr1, aerr1}); end
        total++; if (maddr1 !== 32'd0) begin bad++; $display("FAIL reset_addr1: got %h want 0", maddr1); end
        total++; if (mwd1 !== 32'd0) begin bad++; $display("FAIL reset_wdata1: got %h want 0", mwd1); end
        total++; if ({busy3, done3, wr3, aerr3, maddr3, mwd3} !== 68'd0) begin bad++; $display("FAIL reset_dut3: got %b %h %h", {busy3, done3, wr3, aerr3}, maddr3, mwd3); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_word();
        int wc, wn, dc; logic [31:0] wa, wv;
        do_store(1, 2'd0, 32'h10, 32'hDEADBEEF, wc, wn, dc, wa, wv);
        total++; if (wc !== 1) begin bad++; $display("FAIL word_wr_cycle: got %0d want 1", wc); end
        total++; if (wn !== 1) begin bad++; $display("FAIL word_wr_count: got %0d want 1", wn); end
        total++; if (dc !== 2) begin bad++; $display("FAIL word_done_cycle: got %0d want 2", dc); end
        total++; if (wa !== 32'h10) begin bad++; $display("FAIL word_addr: got %h want 00000010", wa); end
        total++; if (wv !== 32'hDEADBEEF) begin bad++; $display("FAIL word_data: got %h want deadbeef", wv); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL word_idle_after: busy %b want 0", busy1); end
    endtask

    task automatic test_byte();
        int wc, wn, dc; logic [31:0] wa, wv;
        preload(1, 6'd8, 32'h11223344);
        do_store(1, 2'd1, 32'h22, 32'h000000AB, wc, wn, dc, wa, wv);
        total++; if (wc !== 4) begin bad++; $display("FAIL byte_wr_cycle: got %0d want 4", wc); end
        total++; if (dc !== 5) begin bad++; $display("FAIL byte_done_cycle: got %0d want 5", dc); end
        total++; if (wa !== 32'h20) begin bad++; $display("FAIL byte_addr: got %h want 00000020", wa); end
        total++; if (wv !== 32'h11AB3344) begin bad++; $display("FAIL byte_data: got %h want 11ab3344", wv); end
        do_store(1, 2'd1, 32'h23, 32'hFFFFFF77, wc, wn, dc, wa, wv);
        total++; if (ram1[8] !== 32'h77AB3344) begin bad++; $display("FAIL byte_lane3_ram: got %h want 77ab3344", ram1[8]); end
        do_store(1, 2'd1, 32'h20, 32'h000000C5, wc, wn, dc, wa, wv);
        total++; if (ram1[8] !== 32'h77AB33C5) begin bad++; $display("FAIL byte_lane0_ram: got %h want 77ab33c5", ram1[8]); end
    endtask

    task automatic test_half();
        int wc, wn, dc; logic [31:0] wa, wv;
        preload(1, 6'd16, 32'hAABBCCDD);
        do_store(1, 2'd2, 32'h42, 32'h00001234, wc, wn, dc, wa, wv);
        total++; if (dc !== 5) begin bad++; $display("FAIL half_done_cycle: got %0d want 5", dc); end
        total++; if (wv !== 32'h1234CCDD) begin bad++; $display("FAIL half_data: got %h want 1234ccdd", wv); end
        total++; if (ram1[16] !== 32'h1234CCDD) begin bad++; $display("FAIL half_ram: got %h want 1234ccdd", ram1[16]); end
        preload(3, 6'd16, 32'hAABBCCDD);
        do_store(3, 2'd2, 32'h42, 32'h00001234, wc, wn, dc, wa, wv);
        total++; if (wc !== 6) begin bad++; $display("FAIL half_lat3_wr_cycle: got %0d want 6", wc); end
        total++; if (dc !== 7) begin bad++; $display("FAIL half_lat3_done_cycle: got %0d want 7", dc); end
        total++; if (wv !== 32'h1234CCDD) begin bad++; $display("FAIL half_lat3_data: got %h want 1234ccdd", wv); end
        do_store(3, 2'd2, 32'h40, 32'hFFFF5678, wc, wn, dc, wa, wv);
        total++; if (ram3[16] !== 32'h12345678) begin bad++; $display("FAIL half_lat3_low_ram: got %h want 12345678", ram3[16]); end
    endtask

    task automatic test_reserved();
        int wc, wn, dc; logic [31:0] wa, wv;
        do_store(1, 2'd3, 32'h60, 32'h12345678, wc, wn, dc, wa, wv);
        total++; if (wn !== 0) begin bad++; $display("FAIL rsvd_wr_count: got %0d want 0", wn); end
        total++; if (dc !== 1) begin bad++; $display("FAIL rsvd_done_cycle: got %0d want 1", dc); end
    endtask

    task automatic test_back_to_back();
        int wn, wc, dc;
        logic [31:0] wa, wv;
        logic        b6, b7;
        wn = 0; wc = -1; dc = -1; wa = 32'd0; wv = 32'd0; b6 = 1'b1; b7 = 1'b1;
        preload(1, 6'd12, 32'hCAFEF00D);
        preload(1, 6'd32, 32'h01010101);
        size = 2'd1; addr = 32'h31; wdata = 32'h0000005A; start1 = 1'b1;
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) begin size = 2'd0; addr = 32'h80; wdata = 32'hFFFFFFFF; start1 = 1'b1; end
            if (c == 2) start1 = 1'b0;
            if (c == 5) start1 = 1'b1;
            if (c == 6) start1 = 1'b0;
            if (wr1) begin wn++; if (wc < 0) begin wc = c; wa = maddr1; wv = mwd1; end end
            if (done1 && dc < 0) dc = c;
            if (c == 6) b6 = busy1;
            if (c == 7) b7 = busy1;
            tick();
        end
        total++; if (wn !== 1) begin bad++; $display("FAIL busy_wr_count: got %0d want 1", wn); end
        total++; if (wc !== 4) begin bad++; $display("FAIL busy_wr_cycle: got %0d want 4", wc); end
        total++; if (wa !== 32'h30) begin bad++; $display("FAIL busy_addr: got %h want 00000030", wa); end
        total++; if (wv !== 32'hCAFE5A0D) begin bad++; $display("FAIL busy_data: got %h want cafe5a0d", wv); end
        total++; if (dc !== 5) begin bad++; $display("FAIL busy_done_cycle: got %0d want 5", dc); end
        total++; if ({b6, b7} !== 2'b00) begin bad++; $display("FAIL busy_not_requeued: got %b want 00", {b6, b7}); end
        total++; if (ram1[32] !== 32'h01010101) begin bad++; $display("FAIL busy_ram80: got %h want 01010101", ram1[32]); end
    endtask

    task automatic test_reset_midop();
        int wc, wn, dc; logic [31:0] wa, wv;
        preload(1, 6'd20, 32'h55667788);
        size = 2'd1; addr = 32'h50; wdata = 32'h00000099; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if ({busy1, wr1, done1} !== 3'b000) begin bad++; $display("FAIL midrst_outputs: got %b want 000", {busy1, wr1, done1}); end
        total++; if (maddr1 !== 32'd0) begin bad++; $display("FAIL midrst_addr: got %h want 0", maddr1); end
        tick(); tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        total++; if (ram1[20] !== 32'h55667788) begin bad++; $display("FAIL midrst_ram: got %h want 55667788", ram1[20]); end
        do_store(1, 2'd0, 32'h50, 32'h0BADF00D, wc, wn, dc, wa, wv);
        total++; if (dc !== 2) begin bad++; $display("FAIL midrst_next_done: got %0d want 2", dc); end
        total++; if (ram1[20] !== 32'h0BADF00D) begin bad++; $display("FAIL midrst_next_ram: got %h want 0badf00d", ram1[20]); end
    endtask

    task automatic test_align();
        int wc, wn, dc; logic [31:0] wa, wv;
        preload(1, 6'd16, 32'hAABBCCDD);
        do_store(1, 2'd2, 32'h41, 32'h0000BEEF, wc, wn, dc, wa, wv);
`ifdef STORE_MERGE_ALIGN_CHECK_EN
        total++; if (wn !== 0) begin bad++; $display("FAIL align_wr_count: got %0d want 0", wn); end
        total++; if (dc !== 1) begin bad++; $display("FAIL align_done_cycle: got %0d want 1", dc); end
        total++; if (aerr1 !== 1'b1) begin bad++; $display("FAIL align_flag: got %b want 1", aerr1); end
        total++; if (ram1[16] !== 32'hAABBCCDD) begin bad++; $display("FAIL align_ram: got %h want aabbccdd", ram1[16]); end
        do_store(1, 2'd0, 32'h44, 32'h00000001, wc, wn, dc, wa, wv);
        total++; if (aerr1 !== 1'b1) begin bad++; $display("FAIL align_sticky: got %b want 1", aerr1); end
`else
        total++; if (wc !== 4) begin bad++; $display("FAIL noalign_wr_cycle: got %0d want 4", wc); end
        total++; if (wa !== 32'h40) begin bad++; $display("FAIL noalign_addr: got %h want 00000040", wa); end
        total++; if (wv !== 32'hAABBBEEF) begin bad++; $display("FAIL noalign_data: got %h want aabbbeef", wv); end
        total++; if (dc !== 5) begin bad++; $display("FAIL noalign_done_cycle: got %0d want 5", dc); end
        total++; if (aerr1 !== 1'b0) begin bad++; $display("FAIL noalign_flag: got %b want 0", aerr1); end
`endif
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_reserved();
        test_back_to_back();
        test_reset_midop();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
